reg_dump_tx: RTL and testbench



---
 rtl/reg_dump_tx.sv | 132 +++++++++++++
 tb/tb_reg_dump_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - serial read-out of an 8-bit register value (UART-style frame, LSB first)
// Optional even-parity bit: define REG_DUMP_PARITY_EN.
module reg_dump_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       req,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shadow, shadow_n;
    logic          tx_n, busy_n, done_n;
    logic          bit_end;
    logic [2:0]    idx_inc;

    assign bit_end = (cnt == CNT_MAX);
    assign idx_inc = idx + 3'd1;

    // State and registered outputs; reset drops the line to idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shadow <= shadow_n;
            tx     <= tx_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state logic: the value for the next bit is loaded into tx on the
    // same edge that ends the current bit, so tx changes exactly on bit edges.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shadow_n = shadow;
        tx_n     = tx;
        busy_n   = busy;
        done_n   = 1'b0;

        if (state != S_IDLE) begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (req) begin
                    shadow_n = value;
                    state_n  = S_START;
                    busy_n   = 1'b1;
                    tx_n     = 1'b0;
                    cnt_n    = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    idx_n   = 3'd0;
                    tx_n    = shadow[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
`ifdef REG_DUMP_PARITY_EN
                        state_n = S_PARITY;
                        tx_n    = ^shadow;
`else
                        state_n = S_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        idx_n = idx_inc;
                        tx_n  = shadow[idx_inc];
                    end
                end
            end
`ifdef REG_DUMP_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb/tb_reg_dump_tx.sv - scoreboard bench for reg_dump_tx
module tb_reg_dump_tx;

    localparam int CPB = 4;
`ifdef REG_DUMP_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 10 + P;
    localparam int F  = NB * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic       req;
    logic       busy, done, tx;

    reg_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .req   (req),
        .busy  (busy),
        .done  (done),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] frame;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected frame, bit k = k-th bit on the line; parity bit supplied by hand.
    task automatic push(input logic [7:0] v, input logic par, input int gap);
        exp_t e;
        if (P == 1) e.frame = {1'b1, par, v, 1'b0};
        else        e.frame = {1'b0, 1'b1, v, 1'b0};
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic wait_busy(input logic lvl, input int lim);
        int n = 0;
        while (busy !== lvl && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== lvl) check("wait_busy_timeout", {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic send(input logic [7:0] v, input logic par);
        @(posedge clk);
        #1;
        value = v;
        req   = 1'b1;
        push(v, par, -1);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_busy(1'b0, F + 10);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: reconstructs frames from the line and checks against the queue.
    initial begin : monitor
        bit   in_frame = 0;
        bit   pend_done = 0;
        int   c = 0;
        int   idle = 0;
        exp_t cur;
        cur.frame = '0;
        cur.gap   = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame  = 0;
                pend_done = 0;
                idle      = 0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    if (q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                        cur.frame = '1;
                        cur.gap   = -1;
                    end else begin
                        cur = q.pop_front();
                    end
                    if (cur.gap >= 0) check("idle_gap", idle, cur.gap);
                    if (pend_done) check("done_missing", {31'd0, done}, 32'd1);
                    in_frame  = 1;
                    pend_done = 0;
                    c         = 0;
                end
                if (in_frame) begin
                    check("tx_bit", {31'd0, tx}, {31'd0, cur.frame[c / CPB]});
                    check("busy_in_frame", {31'd0, busy}, 32'd1);
                    check("done_in_frame", {31'd0, done}, 32'd0);
                    c++;
                    if (c == F) begin
                        in_frame  = 0;
                        pend_done = 1;
                        idle      = 0;
                    end
                end else begin
                    if (pend_done) begin
                        check("done_pulse", {31'd0, done}, 32'd1);
                        pend_done = 0;
                    end else begin
                        check("done_idle", {31'd0, done}, 32'd0);
                    end
                    check("busy_idle", {31'd0, busy}, 32'd0);
                    idle++;
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        value = 8'h00;
        req   = 1'b0;
        #12;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        #5;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_tx", {31'd0, tx}, 32'd1);

        // Single frame, A5 (parity 0).
        send(8'hA5, 1'b0);

        // Snapshot and ignore: 0F accepted, value changed and req pulsed mid-frame.
        @(posedge clk);
        #1;
        value = 8'h0F;
        req   = 1'b1;
        push(8'h0F, 1'b0, -1);
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        value = 8'hF0;
        req   = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_busy(1'b0, F + 10);
        repeat (3) @(posedge clk);
        #1;

        // Continuous request: two frames, one idle cycle between.
        value = 8'h3C;
        req   = 1'b1;
        push(8'h3C, 1'b0, -1);
        push(8'h3C, 1'b0, 1);
        wait_busy(1'b1, 5);
        wait_busy(1'b0, F + 10);
        wait_busy(1'b1, 5);
        req = 1'b0;
        wait_busy(1'b0, F + 10);
        repeat (3) @(posedge clk);
        #1;

        // Reset during data bit 3 (value 55 has bit3=0 so tx must rise).
        value = 8'h55;
        req   = 1'b1;
        push(8'h55, 1'b0, -1);
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (4 * CPB) @(posedge clk);
        #3;
        check("pre_reset_tx", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(8'h81, 1'b0);

        // Odd-parity data value.
        send(8'h07, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
